// File: rtl/ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: default widths,
// op encoding and the response-tag layout.
package ram_arb_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int NUM_REQ_DEF      = 4;
  localparam int TAG_ID_WIDTH_DEF = 4;

  // Request op encoding carried on req_we / ram_we
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Response tag at its widest (16 requesters). The top declares a copy
  // sized to its own ID width.
  typedef struct packed {
    logic                        vld;
    logic [TAG_ID_WIDTH_DEF-1:0] id;
  } rsp_tag_t;

  // Increment an index modulo n
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter with a round-robin pointer.
// When RAM_ARB_FIXED_PRIO_EN is defined, the lowest valid index always wins
// and the pointer register is not built.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] gnt_idx_o,
  output logic                gnt_any_o
);

  logic [ID_WIDTH-1:0] base;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0
  assign base = '0;
`else
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;

  assign base  = ptr_q;
  assign ptr_d = ID_WIDTH'(wrap_inc(int'(gnt_idx_o), NUM_REQ));

  // Pointer moves just past the requester granted this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any_o) begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Pick the first valid requester at or after base, wrapping around
  always_comb begin
    int  idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    found     = 1'b0;
    idx       = 0;
    if (rst_n && en_i) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = int'(base) + off;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req_valid_i[idx]) begin
          found       = 1'b1;
          gnt_o[idx]  = 1'b1;
          gnt_idx_o   = ID_WIDTH'(idx);
        end
      end
      gnt_any_o = found;
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Shares one single-port synchronous-read RAM between NUM_REQ requesters.
// One granted command per cycle is registered onto the RAM port; read data
// comes back two cycles after the handshake, tagged with the requester ID.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (see rr_arbiter).
module ram_sp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
);

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  logic [ID_WIDTH-1:0]   gnt_idx;
  logic                  gnt_any;

  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ID_WIDTH-1:0]   cmd_id_q, cmd_id_d;
  tag_t                  tag_q, tag_d;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .req_valid_i (req_valid),
    .gnt_o       (req_ready),
    .gnt_idx_o   (gnt_idx),
    .gnt_any_o   (gnt_any)
  );

  // Command next-state: load the granted request, otherwise idle with
  // address/data held so the RAM pins do not toggle needlessly
  always_comb begin
    cs_d     = gnt_any;
    we_d     = gnt_any & req_we[gnt_idx];
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cmd_id_d = cmd_id_q;
    if (gnt_any) begin
      addr_d   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d  = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      cmd_id_d = gnt_idx;
    end
  end

  // Tag next-state: a read on the RAM port this cycle responds next cycle
  always_comb begin
    tag_d     = '0;
    tag_d.vld = cs_q & (we_q == OP_RD);
    tag_d.id  = cmd_id_q;
  end

  // Command register driving the RAM port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_id_q <= '0;
    end else begin
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cmd_id_q <= cmd_id_d;
    end
  end

  // Response tag aligned with the RAM read data; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign ram_cs      = cs_q;
  assign ram_we      = we_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;

  assign rsp_valid = tag_q.vld;
  assign rsp_id    = tag_q.id;
  assign rsp_data  = ram_data_out;

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port, synchronous-read RAM (1-cycle read latency, cs/we/address/data_in/data_out port) between NUM_REQ requesters.
- Typical requesters are the LDPC variable-node and check-node units.
- Registers one granted command per cycle onto the RAM port and returns read data tagged with the requester ID.
- Sits between the node-processing units and the message RAM.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 8, RAM address width.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, $clog2(NUM_REQ), requester ID width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  arbitration enable; 0 = issue no new grants.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_we  in  NUM_REQ  per-requester op; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- rsp_valid  out  1  read response valid; single-cycle pulse, no backpressure.
- rsp_id  out  ID_WIDTH  requester index of the response.
- rsp_data  out  DATA_WIDTH  read data.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (rst_n=0 at an edge) sets the following:
  - ram_cs=0, ram_we=0, ram_address=0, ram_data_in=0.
  - rsp_valid=0, rsp_id=0.
  - RR pointer=0, so requester 0 has highest priority.
- While rst_n=0, req_ready=0.
- Grant, cycle T (combinational):
  - If en=1 and any req_valid is set, exactly one req_ready is asserted: the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - A handshake is req_valid[i] & req_ready[i].
  - req_ready never depends on rsp state.
- Command stage, edge ending T:
  - ram_cs<=1, ram_we<=req_we[g], ram_address<=req_addr[g], ram_data_in<=req_wdata[g].
  - Pointer <= g+1 mod NUM_REQ.
  - With no handshake: ram_cs<=0, ram_we<=0; address and data hold their values.
- Read pipeline:
  - For a read, the RAM samples at the edge ending T+1.
  - A tag register latches (read, g) at that same edge.
  - In cycle T+2: rsp_valid=1, rsp_id=g, rsp_data=ram_data_out (passthrough).
  - Read latency is 2 cycles from handshake to rsp_valid.
- Writes complete at the edge ending T+1 and produce no response.
- Throughput is one command per cycle, so back-to-back grants are allowed.
- Ordering:
  - Commands hit the RAM in grant order.
  - A write granted at T followed by a read of the same address granted at T+1 returns the new data.
- Invalid pointer requester: if the pointer's requester is not valid, the search continues from it, wrapping around; no idle cycle is inserted.
- en=0: no new grants; in-flight commands and responses still complete.
- Reset mid-operation: all in-flight commands are dropped, and no rsp_valid is issued for them.

Optional Feature:
- RAM_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest valid index always wins and the pointer register is removed.
- Undefined (default): round-robin as described above.
- Latency and the handshake are identical in both modes.

Decomposition:
- Package ram_arb_pkg holds:
  - default widths;
  - the op encoding localparams OP_RD=0, OP_WR=1;
  - a response-tag struct {logic vld; logic [ID_WIDTH-1:0] id;} parameterised via a default ID_WIDTH of 4 (width adjusted at instantiation).
- Sub-module rr_arbiter (NUM_REQ) contains the combinational one-hot grant plus the pointer register.
- The fixed-priority macro is handled inside rr_arbiter.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=8, NUM_REQ=4, real single-port RAM model attached):
1. rst_n=0 for 3 cycles with req_valid=4'hF, en=1 -> req_ready=0, ram_cs=0, rsp_valid=0 throughout; first grant after release goes to req 0.
2. Req0 writes 0xA5 to 0x10; later req2 reads 0x10 -> rsp_valid exactly 2 cycles after the read handshake, rsp_id=2, rsp_data=0xA5, single-cycle pulse.
3. All 4 requesters continuously reading addr=i (RAM preloaded data=addr) for 16 cycles -> grant sequence 0,1,2,3 repeating; rsp_id follows the same sequence; rsp_data==i each time. With RAM_ARB_FIXED_PRIO_EN -> req 0 granted every cycle.
4. Req1 writes 0x3C to 0x20 at T; req3 reads 0x20 at T+1 -> rsp at T+3: rsp_id=3, rsp_data=0x3C.
5. Read handshake at T, then en=0 from T+1 with all valid -> response still appears at T+2; req_ready=0 while en=0.
6. Read handshake at T, then rst_n=0 during T+1 -> no rsp_valid at T+2 or later; after release, req 0 has priority again.
